// File: rtl/bitonic_merge_sched.sv
// bitonic_merge_sched
//   Sequencer for a single bitonic merger. Two sorted bundle streams (s0, s1)
//   are interleaved into the merger's first input, smallest head key first,
//   then the end-of-job protocol (last, one idle cycle, drain) is generated
//   and completion is flagged on o_done.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 arm a new job (honoured only when idle)
//   i_s0_* / o_s0_ready     stream 0 head bundle: valid, data, last, pop
//   i_s1_* / o_s1_ready     stream 1 head bundle: valid, data, last, pop
//   i_out_afull             downstream almost full, blocks new issues
//   o_m_valid/bundle/last   registered feed to the merger (i_valid, i_bundle_0, i_last)
//   o_busy                  job in progress
//   o_done                  one-cycle job-complete pulse
//   o_state                 current FSM state, for observation only
//
// Handshake: a stream bundle is consumed in any cycle where its valid and
// ready are both high. Ready is combinational, never asserted for both
// streams at once, and never asserted without the matching valid. The
// consumed bundle is presented on o_m_bundle with o_m_valid one cycle later.

module bitonic_merge_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEY_WIDTH    = 32,
  parameter int BUNDLE_WIDTH = 16,
  parameter int ISSUE_GAP    = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic                               i_s0_valid,
  input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_s0_bundle,
  input  logic                               i_s0_last,
  output logic                               o_s0_ready,
  input  logic                               i_s1_valid,
  input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_s1_bundle,
  input  logic                               i_s1_last,
  output logic                               o_s1_ready,
  input  logic                               i_out_afull,
  output logic                               o_m_valid,
  output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] o_m_bundle,
  output logic                               o_m_last,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [2:0]                         o_state
);

  localparam int BW        = DATA_WIDTH * BUNDLE_WIDTH;
  localparam int STAGE_NUM = $clog2(BUNDLE_WIDTH) + 1;
  localparam int PW        = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  // o_done fires STAGE_NUM+2 cycles after the last-issue (GAP) cycle; DRAIN
  // is entered one cycle after GAP, so the drain count ends at STAGE_NUM+1.
  localparam int DONE_AT   = STAGE_NUM + 1;
  localparam int DW        = $clog2(DONE_AT + 1);

  localparam logic [PW-1:0] PACE_LOAD  = PW'(ISSUE_GAP - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DONE_AT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MERGE = 3'd1;
  localparam logic [2:0] S_TAIL0 = 3'd2;  // s1 exhausted, draining s0
  localparam logic [2:0] S_TAIL1 = 3'd3;  // s0 exhausted, draining s1
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]    state, state_nx;
  logic [PW-1:0] pace_cnt;
  logic [DW-1:0] drain_cnt;
  logic          issue_ok;
  logic          s0_rdy, s1_rdy, pop, final_pop, done;
  logic [BW-1:0] pop_bundle;
  logic          m_valid, m_last;
  logic [BW-1:0] m_bundle;

  assign issue_ok = ~i_out_afull && (pace_cnt == '0);
  assign done     = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

  always_comb begin
    s0_rdy   = 1'b0;
    s1_rdy   = 1'b0;
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (i_start) state_nx = S_MERGE;
      end
      S_MERGE: begin
        if (i_s0_valid && i_s1_valid && issue_ok) begin
          // Ties go to s0.
          if (i_s0_bundle[KEY_WIDTH-1:0] <= i_s1_bundle[KEY_WIDTH-1:0]) begin
            s0_rdy = 1'b1;
            if (i_s0_last) state_nx = S_TAIL1;
          end else begin
            s1_rdy = 1'b1;
            if (i_s1_last) state_nx = S_TAIL0;
          end
        end
      end
      S_TAIL0: begin
        if (i_s0_valid && issue_ok) begin
          s0_rdy = 1'b1;
          if (i_s0_last) state_nx = S_GAP;
        end
      end
      S_TAIL1: begin
        if (i_s1_valid && issue_ok) begin
          s1_rdy = 1'b1;
          if (i_s1_last) state_nx = S_GAP;
        end
      end
      S_GAP: begin
        state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (done) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign pop        = s0_rdy | s1_rdy;
  assign pop_bundle = s0_rdy ? i_s0_bundle : i_s1_bundle;
  // Only a tail pop of a last bundle moves to GAP, so this marks the final issue.
  assign final_pop  = pop && (state_nx == S_GAP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      pace_cnt  <= '0;
      drain_cnt <= '0;
      m_valid   <= 1'b0;
      m_bundle  <= '0;
      m_last    <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop)                 pace_cnt <= PACE_LOAD;
      else if (pace_cnt != '0) pace_cnt <= pace_cnt - 1'b1;
      if (state == S_GAP)                drain_cnt <= '0;
      else if (state == S_DRAIN && !done) drain_cnt <= drain_cnt + 1'b1;
      m_valid <= pop;
      if (pop) m_bundle <= pop_bundle;
      m_last  <= final_pop;
    end
  end

  assign o_s0_ready = s0_rdy;
  assign o_s1_ready = s1_rdy;
  assign o_m_valid  = m_valid;
  assign o_m_bundle = m_bundle;
  assign o_m_last   = m_last;
  assign o_busy     = (state != S_IDLE);
  assign o_done     = done;
  assign o_state    = state;

endmodule

// File: tb/tb_bitonic_merge_sched.sv
module tb_bitonic_merge_sched;

  localparam int W = 32;  // 4 elements x 8 bits

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: ISSUE_GAP = 1 ----------------
  logic         start = 1'b0, s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic         afull = 1'b0;
  logic [W-1:0] s0_bundle = '0, s1_bundle = '0;
  logic         s0_ready, s1_ready, m_valid, m_last, busy, done;
  logic [W-1:0] m_bundle;
  logic [2:0]   state;

  bitonic_merge_sched #(.DATA_WIDTH(8), .KEY_WIDTH(8), .BUNDLE_WIDTH(4), .ISSUE_GAP(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_s0_valid(s0_valid), .i_s0_bundle(s0_bundle), .i_s0_last(s0_last), .o_s0_ready(s0_ready),
    .i_s1_valid(s1_valid), .i_s1_bundle(s1_bundle), .i_s1_last(s1_last), .o_s1_ready(s1_ready),
    .i_out_afull(afull), .o_m_valid(m_valid), .o_m_bundle(m_bundle), .o_m_last(m_last),
    .o_busy(busy), .o_done(done), .o_state(state)
  );

  // ---------------- DUT B: ISSUE_GAP = 3 ----------------
  logic         g_start = 1'b0, g_s0_valid = 1'b0, g_s0_last = 1'b0, g_s1_valid = 1'b0, g_s1_last = 1'b0;
  logic         g_afull = 1'b0;
  logic [W-1:0] g_s0_bundle = '0, g_s1_bundle = '0;
  logic         g_s0_ready, g_s1_ready, g_m_valid, g_m_last, g_busy, g_done;
  logic [W-1:0] g_m_bundle;
  logic [2:0]   g_state;

  bitonic_merge_sched #(.DATA_WIDTH(8), .KEY_WIDTH(8), .BUNDLE_WIDTH(4), .ISSUE_GAP(3)) dut_g (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(g_start),
    .i_s0_valid(g_s0_valid), .i_s0_bundle(g_s0_bundle), .i_s0_last(g_s0_last), .o_s0_ready(g_s0_ready),
    .i_s1_valid(g_s1_valid), .i_s1_bundle(g_s1_bundle), .i_s1_last(g_s1_last), .o_s1_ready(g_s1_ready),
    .i_out_afull(g_afull), .o_m_valid(g_m_valid), .o_m_bundle(g_m_bundle), .o_m_last(g_m_last),
    .o_busy(g_busy), .o_done(g_done), .o_state(g_state)
  );

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] st0[$];
  logic [W-1:0] st1[$];
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [W-1:0] exp_hold = '0;   // value o_m_bundle must hold between issues

  localparam int DONE_DELAY = 5;  // STAGE_NUM + 2 with BUNDLE_WIDTH = 4

  // Reference: merge of two sorted bundle lists by element-0 key, ties to s0;
  // the single last flag belongs to the final bundle of the whole job.
  function automatic void build_expected();
    int i = 0;
    int j = 0;
    logic [W-1:0] a, b;
    exp_q.delete();
    exp_last_q.delete();
    while (i < st0.size() || j < st1.size()) begin
      if (i < st0.size()) a = st0[i]; else a = '0;
      if (j < st1.size()) b = st1[j]; else b = '0;
      if (j >= st1.size() || (i < st0.size() && a[7:0] <= b[7:0])) begin
        exp_q.push_back(a); i++;
      end else begin
        exp_q.push_back(b); j++;
      end
    end
    for (int k = 0; k < exp_q.size(); k++) exp_last_q.push_back(k == exp_q.size() - 1);
  endfunction

  function automatic logic [W-1:0] mk(input int k, input int step);
    logic [W-1:0] r;
    for (int e = 0; e < 4; e++) r[e*8 +: 8] = 8'(k + e * step);
    return r;
  endfunction

  function automatic void gen_random_streams();
    int n0, n1, k0, k1;
    st0.delete(); st1.delete();
    n0 = $urandom_range(1, 4);
    n1 = $urandom_range(1, 4);
    k0 = $urandom_range(0, 20);
    k1 = ($urandom_range(0, 2) == 0) ? k0 : $urandom_range(0, 20);
    for (int i = 0; i < n0; i++) begin
      st0.push_back(mk(k0, $urandom_range(0, 25)));
      k0 += $urandom_range(0, 40);
    end
    for (int i = 0; i < n1; i++) begin
      st1.push_back(mk(k1, $urandom_range(0, 25)));
      k1 += $urandom_range(0, 40);
    end
  endfunction

  // ---------------- tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({m_valid, m_bundle, m_last, busy, done, s0_ready, s1_ready} !== '0) begin
      n_err++; $display("FAIL reset_a: outputs %h expected 0", {m_valid, m_bundle, m_last, busy, done, s0_ready, s1_ready});
    end
    n_cmp++;
    if ({g_m_valid, g_m_bundle, g_m_last, g_busy, g_done, g_s0_ready, g_s1_ready} !== '0) begin
      n_err++; $display("FAIL reset_g: outputs %h expected 0", {g_m_valid, g_m_bundle, g_m_last, g_busy, g_done});
    end
    rst_n = 1'b1;
    exp_hold = '0;
  endtask

  // Runs one job on DUT A from st0/st1.
  // afull_mode: 0 never, 1 random, 2 four cycles once s0 is exhausted.
  task automatic run_job(input int valid_pct, input int afull_mode, input bit start_spam);
    int p0 = 0, p1 = 0, n0, n1, cyc = 0, last_cyc = -1, af_cnt = 0;
    bit prev_pop = 1'b0, done_seen = 1'b0, af_done = 1'b0, expect_resume;
    n0 = st0.size(); n1 = st1.size();
    build_expected();
    // start cycle: streams already valid while idle, must not be popped
    @(negedge clk);
    start = 1'b1;
    s0_valid = 1'b1; s0_bundle = st0[0]; s0_last = (n0 == 1);
    s1_valid = 1'b1; s1_bundle = st1[0]; s1_last = (n1 == 1);
    afull = 1'b0;
    #1;
    n_cmp++;
    if ({s0_ready, s1_ready} !== 2'b00) begin
      n_err++; $display("FAIL idle_ready: got %b expected 00", {s0_ready, s1_ready});
    end
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      // observe registered outputs
      n_cmp++;
      if (m_valid !== prev_pop) begin
        n_err++; $display("FAIL m_valid: cycle %0d got %b expected %b", cyc, m_valid, prev_pop);
      end
      if (m_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL extra_issue: got %h expected no issue", m_bundle);
        end else begin
          if (m_bundle !== exp_q[0] || m_last !== exp_last_q[0]) begin
            n_err++; $display("FAIL issue: got %h/%b expected %h/%b", m_bundle, m_last, exp_q[0], exp_last_q[0]);
          end
          if (exp_last_q[0]) last_cyc = cyc;
          void'(exp_q.pop_front()); void'(exp_last_q.pop_front());
        end
      end else begin
        n_cmp++;
        if (m_bundle !== exp_hold || m_last !== 1'b0) begin
          n_err++; $display("FAIL hold: got %h/%b expected %h/0", m_bundle, m_last, exp_hold);
        end
      end
      n_cmp++;
      if (last_cyc >= 0 && cyc == last_cyc + DONE_DELAY) begin
        if (done !== 1'b1) begin n_err++; $display("FAIL done_time: got %b expected 1 at cycle %0d", done, cyc); end
      end else if (done !== 1'b0) begin
        n_err++; $display("FAIL done_early: got %b expected 0 at cycle %0d (last %0d)", done, cyc, last_cyc);
      end
      if (done === 1'b1) done_seen = 1'b1;
      if (cyc == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_start: got %b expected 1", busy); end
      end
      // drive next cycle
      start = start_spam && (last_cyc >= 0);
      expect_resume = 1'b0;
      case (afull_mode)
        1: afull = ($urandom_range(0, 3) == 0);
        2: begin
          afull = 1'b0;
          if (!af_done && p0 == n0 && p1 < n1) begin
            afull = (af_cnt < 4);
            if (af_cnt == 4) begin af_done = 1'b1; expect_resume = 1'b1; end
            af_cnt++;
          end
        end
        default: afull = 1'b0;
      endcase
      if (p0 < n0) begin
        s0_valid = ($urandom_range(1, 100) <= valid_pct); s0_bundle = st0[p0]; s0_last = (p0 == n0 - 1);
      end else begin
        s0_valid = 1'($urandom_range(0, 1)); s0_bundle = 32'($urandom()); s0_last = 1'($urandom_range(0, 1));
      end
      if (p1 < n1) begin
        s1_valid = ($urandom_range(1, 100) <= valid_pct); s1_bundle = st1[p1]; s1_last = (p1 == n1 - 1);
      end else begin
        s1_valid = 1'($urandom_range(0, 1)); s1_bundle = 32'($urandom()); s1_last = 1'($urandom_range(0, 1));
      end
      #1;
      n_cmp++;
      if ((s0_ready && s1_ready) || (s0_ready && !s0_valid) || (s1_ready && !s1_valid) ||
          ((s0_ready || s1_ready) && afull) || (s0_ready && p0 >= n0) || (s1_ready && p1 >= n1)) begin
        n_err++; $display("FAIL ready_rule: got %b%b expected legal (v=%b%b af=%b p=%0d/%0d %0d/%0d)",
                          s0_ready, s1_ready, s0_valid, s1_valid, afull, p0, n0, p1, n1);
      end
      if (expect_resume) begin
        n_cmp++;
        if (s1_ready !== 1'b1) begin n_err++; $display("FAIL afull_resume: got %b expected 1", s1_ready); end
      end
      if (af_cnt > 0 && af_cnt <= 4 && !af_done) begin
        n_cmp++;
        if (m_valid !== 1'b0 && af_cnt > 1) begin n_err++; $display("FAIL afull_issue: got %b expected 0", m_valid); end
      end
      prev_pop = s0_ready | s1_ready;
      if (s0_ready) begin exp_hold = st0[p0]; p0++; end
      else if (s1_ready) begin exp_hold = st1[p1]; p1++; end
    end
    n_cmp++;
    if (!done_seen || exp_q.size() != 0) begin
      n_err++; $display("FAIL job_end: done %b left %0d expected done 1 left 0", done_seen, exp_q.size());
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b000) begin
      n_err++; $display("FAIL after_done: busy/done/valid %b expected 000", {busy, done, m_valid});
    end
    start = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; afull = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    st0 = '{mk(1, 1), mk(10, 1), mk(20, 1)};
    st1 = '{mk(2, 1), mk(11, 1), mk(21, 1)};
    @(negedge clk);
    start = 1'b1; s0_valid = 1'b1; s0_bundle = st0[0]; s1_valid = 1'b1; s1_bundle = st1[0];
    @(negedge clk);
    start = 1'b0;   // MERGE now; st0[0] pops at the next edge
    @(negedge clk);
    s0_bundle = st0[1];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_bundle, m_last, busy, done, s0_ready, s1_ready} !== '0) begin
      n_err++; $display("FAIL reset_mid: outputs %h expected 0", {m_valid, m_bundle, m_last, busy, done, s0_ready, s1_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hold = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({s0_ready, s1_ready, done, busy, m_valid} !== 5'b0) begin
        n_err++; $display("FAIL post_reset_idle: rdy/done/busy/valid %b expected 0", {s0_ready, s1_ready, done, busy, m_valid});
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_basic();
    st0 = '{32'h07050301};
    st1 = '{32'h08060402};
    run_job(100, 0, 1'b0);
  endtask

  task automatic test_tie();
    st0 = '{mk(4, 1), mk(30, 2)};
    st1 = '{mk(4, 5), mk(30, 3)};
    run_job(100, 0, 1'b0);
  endtask

  task automatic test_afull_tail();
    st0 = '{mk(1, 1), mk(10, 1)};
    st1 = '{mk(5, 1), mk(20, 1), mk(30, 1)};
    run_job(100, 2, 1'b0);
  endtask

  task automatic test_start_in_drain();
    gen_random_streams();
    run_job(100, 0, 1'b1);
    gen_random_streams();
    run_job(80, 0, 1'b0);   // a fresh start must still be accepted
  endtask

  task automatic test_issue_gap();
    int p0 = 0, p1 = 0, n0, n1, cyc = 0, last_cyc = -1, prev_iss = -1, n_iss = 0;
    bit done_seen = 1'b0;
    st0 = '{mk(10, 1), mk(20, 1), mk(30, 1)};
    st1 = '{mk(25, 1)};
    n0 = 3; n1 = 1;
    build_expected();
    @(negedge clk);
    g_start = 1'b1;
    g_s0_valid = 1'b1; g_s0_bundle = st0[0]; g_s0_last = 1'b0;
    g_s1_valid = 1'b1; g_s1_bundle = st1[0]; g_s1_last = 1'b1;
    while (!done_seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      g_start = 1'b0;
      if (g_m_valid === 1'b1) begin
        n_iss++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL gap_extra: got %h expected no issue", g_m_bundle);
        end else begin
          if (g_m_bundle !== exp_q[0] || g_m_last !== exp_last_q[0]) begin
            n_err++; $display("FAIL gap_issue: got %h/%b expected %h/%b", g_m_bundle, g_m_last, exp_q[0], exp_last_q[0]);
          end
          if (exp_last_q[0]) last_cyc = cyc;
          void'(exp_q.pop_front()); void'(exp_last_q.pop_front());
        end
        if (prev_iss >= 0) begin
          n_cmp++;
          if (cyc - prev_iss != 3) begin n_err++; $display("FAIL gap_spacing: got %0d expected 3", cyc - prev_iss); end
        end
        prev_iss = cyc;
      end
      if (g_done === 1'b1) begin
        done_seen = 1'b1;
        n_cmp++;
        if (last_cyc < 0 || cyc != last_cyc + DONE_DELAY) begin
          n_err++; $display("FAIL gap_done: got cycle %0d expected %0d", cyc, last_cyc + DONE_DELAY);
        end
      end
      g_s0_valid = (p0 < n0); g_s0_bundle = (p0 < n0) ? st0[p0] : '0; g_s0_last = (p0 == n0 - 1);
      g_s1_valid = (p1 < n1); g_s1_bundle = (p1 < n1) ? st1[p1] : '0; g_s1_last = (p1 == n1 - 1);
      #1;
      n_cmp++;
      if (g_s0_ready && g_s1_ready) begin n_err++; $display("FAIL gap_both_ready: got 11 expected one-hot"); end
      if (g_s0_ready) p0++;
      else if (g_s1_ready) p1++;
    end
    n_cmp++;
    if (n_iss != 4 || !done_seen) begin
      n_err++; $display("FAIL gap_count: got %0d issues done %b expected 4 issues done 1", n_iss, done_seen);
    end
    g_s0_valid = 1'b0; g_s1_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 20; j++) begin
      gen_random_streams();
      run_job($urandom_range(40, 100), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_job();
    test_basic();
    test_tie();
    test_issue_gap();
    test_afull_tail();
    test_start_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
